// File: rtl/muldiv_sequencer_pkg.sv
// ============================================================================
// Module      : muldiv_sequencer_pkg
// Description : Shared CPU constants: ALU function codes, multiply/divide op
//               encodings, sequencer FSM states and iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_sequencer_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 5;

    localparam logic [MD_CNT_W-1:0] MD_CNT_LOAD = MD_CNT_W'(MD_ITER - 1);

    // ALU function codes shared with the execute stage
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SLT = 4'h5;

    localparam logic [2:0] MD_OP_MULT  = 3'b000;
    localparam logic [2:0] MD_OP_MULTU = 3'b001;
    localparam logic [2:0] MD_OP_DIV   = 3'b010;
    localparam logic [2:0] MD_OP_DIVU  = 3'b011;
    localparam logic [2:0] MD_OP_MTHI  = 3'b100;
    localparam logic [2:0] MD_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'b00,
        MD_ST_RUN  = 2'b01,
        MD_ST_FIX  = 2'b10
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer_step.sv
// ============================================================================
// Module      : muldiv_step
// Description : One iteration of unsigned shift-add multiply or restoring
//               shift-subtract divide, sharing a single 33-bit adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step
    import muldiv_sequencer_pkg::*;
(
    input  logic                div_mode,
    input  logic [MD_WIDTH-1:0] acc_in,
    input  logic [MD_WIDTH-1:0] q_in,
    input  logic [MD_WIDTH-1:0] m_in,
    output logic [MD_WIDTH-1:0] acc_out,
    output logic [MD_WIDTH-1:0] q_out
);

    logic [MD_WIDTH:0] x;
    logic [MD_WIDTH:0] y;
    logic [MD_WIDTH:0] r;
    logic              ge;

    always_comb begin
        if (div_mode) begin
            x = {acc_in, q_in[MD_WIDTH-1]};
            y = {1'b0, m_in};
        end else begin
            x = {1'b0, acc_in};
            y = q_in[0] ? {1'b0, m_in} : '0;
        end
        r  = div_mode ? (x - y) : (x + y);
        ge = (x >= y);

        // Remainder stays below the divisor, so a restored value fits 32 bits
        if (div_mode) begin
            acc_out = ge ? r[MD_WIDTH-1:0] : x[MD_WIDTH-1:0];
            q_out   = {q_in[MD_WIDTH-2:0], ge};
        end else begin
            acc_out = r[MD_WIDTH:1];
            q_out   = {r[0], q_in[MD_WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative MIPS-style HI/LO multiply/divide unit with abort,
//               MTHI/MTLO writes and MFHI/MFLO stall generation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             mf_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]      q_q, q_d;
    logic [WIDTH-1:0]      m_q, m_d;
    logic [WIDTH-1:0]      hi_q, hi_d;
    logic [WIDTH-1:0]      lo_q, lo_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  dz_q, dz_d;
    logic                  done_q, done_d;

    logic [WIDTH-1:0]      step_acc, step_q;
    logic                  op_signed, op_arith;
    logic [WIDTH-1:0]      a_mag, b_mag;
    logic [2*WIDTH-1:0]    prod_fix;
    logic [WIDTH-1:0]      quo_fix, rem_fix;

    muldiv_step u_step (
        .div_mode (is_div_q),
        .acc_in   (acc_q),
        .q_in     (q_q),
        .m_in     (m_q),
        .acc_out  (step_acc),
        .q_out    (step_q)
    );

    always_comb begin
        op_arith  = (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
                    (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
        op_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
        a_mag     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // Divide-by-zero leaves all-ones quotient; the remainder path already
    // reconstructs the dividend with its original sign.
    always_comb begin
        prod_fix = neg_res_q ? (~{acc_q, q_q} + 1'b1) : {acc_q, q_q};
        quo_fix  = dz_q ? '1 : (neg_res_q ? (~q_q + 1'b1) : q_q);
        rem_fix  = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        case (state_q)
            MD_ST_IDLE: begin
                if (start) begin
                    if (op_arith) begin
                        acc_d     = '0;
                        q_d       = a_mag;
                        m_d       = b_mag;
                        is_div_d  = op[1];
                        neg_res_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = op_signed && op[1] && a[WIDTH-1];
                        dz_d      = op[1] && (b == '0);
                        cnt_d     = MD_CNT_LOAD;
                        state_d   = MD_ST_RUN;
                    end else if (op == MD_OP_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            MD_ST_RUN: begin
                if (abort) begin
                    state_d = MD_ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    q_d   = step_q;
                    if (cnt_q == '0) begin
                        state_d = MD_ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            MD_ST_FIX: begin
                state_d = MD_ST_IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = MD_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q != MD_ST_IDLE);
    assign done  = done_q;
    assign stall = mf_req && busy;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer against an
//               arithmetic HI/LO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    localparam logic [2:0] T_MULT  = 3'b000;
    localparam logic [2:0] T_MULTU = 3'b001;
    localparam logic [2:0] T_DIV   = 3'b010;
    localparam logic [2:0] T_DIVU  = 3'b011;
    localparam logic [2:0] T_MTHI  = 3'b100;
    localparam logic [2:0] T_MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic        mf_req = 1'b0;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural HI/LO as the bench expects them
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .abort  (abort),
        .mf_req (mf_req),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_md(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                   output logic [31:0] eh, output logic [31:0] el);
        longint      sa, sb, sp;
        logic [63:0] t;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        eh = '0;
        el = '0;
        case (o)
            T_MULT: begin
                sp = sa * sb;
                t  = sp;
                {eh, el} = t;
            end
            T_MULTU: begin
                t = {32'b0, av} * {32'b0, bv};
                {eh, el} = t;
            end
            default: begin
                if (bv == 32'h0) begin
                    el = 32'hFFFF_FFFF;
                    eh = av;
                end else if (o == T_DIV) begin
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                end else begin
                    el = av / bv;
                    eh = av % bv;
                end
            end
        endcase
    endfunction

    // Issues one arithmetic op and follows it to done (or to abort).
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input int abort_at, input bit mf,
                          input bit inj, input bit abort_with_start);
        logic [31:0] eh, el;
        int          k, busy_n, stall_n;
        bit          seen;
        ref_md(o, av, bv, eh, el);
        mf_req = mf;
        start  = 1'b1;
        op     = o;
        a      = av;
        b      = bv;
        abort  = abort_with_start;
        tick();
        start  = 1'b0;
        abort  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        k = 1; busy_n = 0; stall_n = 0; seen = 1'b0;
        while (k <= 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy)  busy_n++;
                if (stall) stall_n++;
                if (k == abort_at) abort = 1'b1;
                if (inj && k == 5)  begin start = 1'b1; op = T_MTLO;  a = 32'hDEAD_BEEF; end
                if (inj && k == 20) begin start = 1'b1; op = T_MULTU; a = 32'h1234; b = 32'h5678; end
                tick();
                abort = 1'b0;
                start = 1'b0;
                k++;
            end
        end
        if (abort_at > 0) begin
            check({tag, " no_done_after_abort"}, 64'(seen), 64'd0);
            check({tag, " busy_after_abort"}, 64'(busy), 64'd0);
            check({tag, " hi_kept"}, 64'(hi), 64'(m_hi));
            check({tag, " lo_kept"}, 64'(lo), 64'(m_lo));
        end else begin
            check({tag, " done_cycle"}, 64'(k), 64'd34);
            check({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
            check({tag, " stall_cycles"}, 64'(stall_n), mf ? 64'd33 : 64'd0);
            check({tag, " busy_in_done"}, 64'(busy), 64'd0);
            check({tag, " stall_in_done"}, 64'(stall), 64'd0);
            check({tag, " hi"}, 64'(hi), 64'(eh));
            check({tag, " lo"}, 64'(lo), 64'(el));
            m_hi = eh;
            m_lo = el;
            tick();
            check({tag, " done_pulse"}, 64'(done), 64'd0);
        end
        mf_req = 1'b0;
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [31:0] v);
        start = 1'b1;
        op    = o;
        a     = v;
        tick();
        start = 1'b0;
        if (o == T_MTHI) m_hi = v;
        else             m_lo = v;
    endtask

    initial begin
        int          gap;
        bit          seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        // Reset state
        #2;
        check("rst_async_hi", 64'(hi), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        tick();

        // Directed arithmetic corners
        run_op("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0);
        check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo_const", 64'(lo), 64'h0000_0001);
        run_op("mult_neg", T_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b0, 1'b0, 1'b0);
        check("mult_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFEB);
        run_op("div_neg", T_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0, 1'b0, 1'b0);
        check("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
        run_op("divu_by0", T_DIVU, 32'h0000_0007, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0);
        check("divu_by0_lo_const", 64'(lo), 64'hFFFF_FFFF);
        check("divu_by0_hi_const", 64'(hi), 64'h0000_0007);
        run_op("div_by0_neg", T_DIV, 32'h8000_0005, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0);
        run_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0);
        check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        check("div_ovf_hi_const", 64'(hi), 64'h0000_0000);

        // MTHI then MFHI
        do_mt(T_MTHI, 32'h1234_5678);
        mf_req = 1'b1;
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_stall", 64'(stall), 64'd0);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        tick();
        mf_req = 1'b0;
        check("mthi_lo_untouched", 64'(lo), 64'(m_lo));
        do_mt(T_MTLO, 32'hCAFE_F00D);
        check("mtlo_lo", 64'(lo), 64'hCAFE_F00D);

        // Stall held across a divide
        run_op("divu_stall", T_DIVU, 32'h9ABC_DEF0, 32'h0000_0013, 0, 1'b1, 1'b0, 1'b0);

        // Aborts: mid-RUN, during FIX, and abort coinciding with an IDLE start
        run_op("mult_abort10", T_MULT, 32'h0001_2345, 32'hFFFF_0007, 10, 1'b0, 1'b0, 1'b0);
        run_op("div_abort_fix", T_DIV, 32'h7FFF_0001, 32'h0000_0101, 33, 1'b0, 1'b0, 1'b0);
        run_op("start_with_abort", T_MULTU, 32'h0000_FFFF, 32'h0001_0001, 0, 1'b0, 1'b0, 1'b1);

        // Starts while busy are ignored
        run_op("busy_inject", T_DIV, 32'hF000_0123, 32'hFFFF_FF10, 0, 1'b0, 1'b1, 1'b0);

        // Undefined ops leave everything alone
        for (int i = 6; i < 8; i++) begin
            start = 1'b1;
            op    = 3'(i);
            a     = 32'h5555_AAAA;
            tick();
            start = 1'b0;
            check("undef_busy", 64'(busy), 64'd0);
            check("undef_hi", 64'(hi), 64'(m_hi));
            check("undef_lo", 64'(lo), 64'(m_lo));
            tick();
            check("undef_done", 64'(done), 64'd0);
        end

        // Reset in the middle of a divide
        do_mt(T_MTHI, 32'h0BAD_CAFE);
        do_mt(T_MTLO, 32'h0000_0042);
        start = 1'b1;
        op    = T_DIVU;
        a     = 32'h0FFF_FFFF;
        b     = 32'h0000_0003;
        tick();
        start = 1'b0;
        repeat (12) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        gap = 0;
        while (gap < 40) begin
            if (done || busy) seen = 1'b1;
            tick();
            gap++;
        end
        check("rst_no_done", 64'(seen), 64'd0);
        run_op("post_reset", T_MULT, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, 1'b0, 1'b0);

        // Randomized operations against the model
        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 5) == 0) rb = 32'h0;
            run_op("rand", ro, ra, rb, 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and HI/LO width; the block SHALL support only 32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle operation request from decode/execute.
REQ-005 The block SHALL have port op, input, 3, with 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are ignored.
REQ-006 The block SHALL have ports a and b, input, 32 each: rs and rt operand values, sampled only on an accepted start.
REQ-007 The block SHALL have port abort, input, 1, a pipeline flush that cancels the in-flight operation.
REQ-008 The block SHALL have port mf_req, input, 1, asserted by an MFHI/MFLO in execute.
REQ-009 The block SHALL have port busy, output, 1, high while a multiply/divide is in flight.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse when new HI/LO values first become visible.
REQ-011 The block SHALL have port stall, output, 1, equal to mf_req AND busy (combinational).
REQ-012 The block SHALL have ports hi and lo, output, 32 each: architectural HI/LO registers.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIX; busy SHALL be high in RUN and FIX only.
REQ-014 A start in IDLE with op MULT/MULTU/DIV/DIVU SHALL be accepted: latch |a|,|b| (signed ops) or a,b, result signs, load counter=31, go to RUN.
REQ-015 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; at counter==0 it SHALL go to FIX, otherwise decrement.
REQ-016 FIX SHALL apply two's-complement sign correction (signed product; quotient sign a^b; remainder sign a), write HI/LO at the end of the FIX cycle, and go to IDLE.
REQ-017 done SHALL be high for exactly the one IDLE cycle following FIX; new HI/LO are visible in that cycle, 34 cycles after the start edge.
REQ-018 For multiply, HI:LO SHALL be the 64-bit product; for divide, LO SHALL be the quotient and HI the remainder.
REQ-019 For divide by zero (both DIV and DIVU), the block SHALL produce LO=FFFFFFFF and HI=a, with normal latency.
REQ-020 For DIV of 80000000 by FFFFFFFF, the block SHALL produce LO=80000000 and HI=00000000.
REQ-021 MTHI/MTLO in IDLE SHALL write a into hi or lo at the start edge; busy and done SHALL stay low.
REQ-022 A start while busy SHALL be ignored; the decode stall logic guarantees it does not occur, and the bench checks that it has no effect.
REQ-023 abort in RUN or FIX SHALL return the FSM to IDLE next edge with hi/lo unchanged and no done; abort has priority over FIX completion.
REQ-024 When abort and start are both high in IDLE, the block SHALL accept the start.
REQ-025 Undefined op values SHALL leave all state unchanged.

Reset
REQ-026 When rst_n is low, the block SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0, and internal operand/accumulator registers to 0.
REQ-027 Reset mid-operation SHALL discard the operation; no done SHALL follow reset release.
REQ-028 Reset deassertion SHALL be synchronised externally; the block SHALL assume a clean release.

Structure
REQ-029 Op encodings, FSM state encodings and the iteration count (32) SHALL live in the shared CPU package alongside the ALU function codes.
REQ-030 The per-cycle arithmetic step SHALL be a single sub-module, muldiv_step, a combinational 33-bit add/subtract-and-shift with a mode input; the FSM, counter, sign handling and HI/LO live in muldiv_sequencer.

Verification
REQ-031 The bench SHALL check MULTU a=FFFFFFFF, b=FFFFFFFF -> done at cycle 34, HI=FFFFFFFE, LO=00000001.
REQ-032 The bench SHALL check MULT a=FFFFFFFD (-3), b=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB.
REQ-033 The bench SHALL check DIV a=FFFFFFF9 (-7), b=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 7/0 -> LO=FFFFFFFF, HI=00000007.
REQ-034 The bench SHALL check MTHI a=12345678 then MFHI with mf_req -> hi=12345678 next cycle, stall=0, busy=0.
REQ-035 The bench SHALL check that mf_req is held during a DIVU: stall stays high for all 33 busy cycles and drops in the done cycle.
REQ-036 The bench SHALL check abort at RUN cycle 10 of MULT, then reset pulse mid-DIVU -> hi/lo hold prior values (reset: 0), no done, and the next start is accepted normally.
